axi_stream_strip_header: RTL and testbench

AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

---
 rtl/axi_stream_hdr_pkg.sv | 15 +
 rtl/axis_byte_realign.sv | 29 ++
 rtl/axi_stream_strip_header.sv | 176 +++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_hdr_pkg.sv
// Shared definitions for the AXI-Stream header strip/insert blocks:
// packet FSM state encoding and default stream widths.
package axi_stream_hdr_pkg;

    localparam int DEF_DATA_WD      = 32;
    localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
    localparam int DEF_BYTE_CNT_WD  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } hdr_state_t;

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational byte realigner: joins the held beat with the incoming beat
// and returns the word that starts N bytes into the held beat.
module axis_byte_realign
    import axi_stream_hdr_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = DEF_BYTE_CNT_WD
) (
    input  logic [DATA_WD-1:0]      hold,
    input  logic [DATA_BYTE_WD-1:0] hold_keep,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic [BYTE_CNT_WD:0]    n,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out
);

    logic [BYTE_CNT_WD+3:0]  bit_shift;
    logic [DATA_WD-1:0]      data_lo_unused;
    logic [DATA_BYTE_WD-1:0] keep_lo_unused;

    assign bit_shift = {n, 3'b000};

    // Double-width join so a shift of a full beat lands exactly on data_in.
    assign {data_out, data_lo_unused} = {hold, data_in} << bit_shift;
    assign {keep_out, keep_lo_unused} = {hold_keep, keep_in} << n;

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte header from the front of each AXI-Stream packet, returning
// the header on its own port and the realigned payload on the output stream.
module axi_stream_strip_header
    import axi_stream_hdr_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = DEF_BYTE_CNT_WD
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,

    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,

    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic [1:0]              state_dbg
);

    // Handshakes: a beat moves on any port only in a cycle where its valid and
    // ready are both high; valid never drops and data never changes while waiting.

    localparam logic [DATA_BYTE_WD-1:0] ALL_KEEP = '1;
    localparam logic [BYTE_CNT_WD:0]    MAX_N    = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    hdr_state_t state, state_nxt;

    logic [BYTE_CNT_WD:0]    n_q;
    logic [DATA_WD-1:0]      hold;
    logic [DATA_BYTE_WD-1:0] hold_keep;

    logic accept, out_free, hdr_free, residual;
    logic out_load, out_last_nxt, hdr_load, hold_load;

    logic [DATA_WD-1:0]      ra_hold, ra_data, ra_data_out;
    logic [DATA_BYTE_WD-1:0] ra_hold_keep, ra_keep, ra_keep_out, keep_inv;
    logic [BYTE_CNT_WD:0]    ra_n;

    assign out_free  = !valid_out || ready_out;
    assign hdr_free  = !valid_header || ready_header;
    assign ready_in  = (state != FLUSH) && out_free && (state != IDLE || hdr_free);
    assign accept    = valid_in && ready_in;
    assign state_dbg = state;

    // On the first beat nothing is held yet, so the beat itself stands in for
    // hold; outside BODY the incoming half is zero-filled.
    assign ra_hold      = (state == IDLE) ? data_in : hold;
    assign ra_hold_keep = (state == IDLE) ? keep_in : hold_keep;
    assign ra_data      = (state == BODY) ? data_in : '0;
    assign ra_keep      = (state == BODY) ? keep_in : '0;
    assign ra_n         = (state == IDLE) ? byte_strip_cnt : n_q;

    // Bytes of the last beat beyond the first N still need a flush beat.
    assign residual = |(keep_in & (ALL_KEEP >> n_q));

    axis_byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .hold      (ra_hold),
        .hold_keep (ra_hold_keep),
        .data_in   (ra_data),
        .keep_in   (ra_keep),
        .n         (ra_n),
        .data_out  (ra_data_out),
        .keep_out  (ra_keep_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !last_in) state_nxt = BODY;
            BODY:    if (accept && last_in)  state_nxt = residual ? FLUSH : IDLE;
            FLUSH:   if (out_free)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_load     = 1'b0;
        out_last_nxt = 1'b0;
        hdr_load     = 1'b0;
        hold_load    = 1'b0;
        case (state)
            IDLE: begin
                hdr_load  = accept;
                hold_load = accept;
                if (accept && last_in && (|ra_keep_out)) begin
                    out_load     = 1'b1;
                    out_last_nxt = 1'b1;
                end
            end
            BODY: begin
                hold_load    = accept;
                out_load     = accept;
                out_last_nxt = last_in && !residual;
            end
            FLUSH: begin
                out_load     = out_free;
                out_last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
            hold         <= '0;
            hold_keep    <= '0;
            n_q          <= '0;
        end else begin
            if (out_load) begin
                valid_out <= 1'b1;
                data_out  <= ra_data_out;
                keep_out  <= ra_keep_out;
                last_out  <= out_last_nxt;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end

            if (hdr_load) begin
                valid_header <= 1'b1;
                data_header  <= data_in;
                keep_header  <= ~(ALL_KEEP >> byte_strip_cnt);
                n_q          <= byte_strip_cnt;
            end else if (ready_header) begin
                valid_header <= 1'b0;
            end

            if (hold_load) begin
                hold      <= data_in;
                hold_keep <= keep_in;
            end
        end
    end

    // Contiguous MSB-aligned keep means its inverse is a block of low ones.
    assign keep_inv = ~keep_in;

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            a_keep_contiguous: assert ((keep_inv & (keep_inv + DATA_BYTE_WD'(1))) == '0);
            if (state == IDLE) begin
                a_strip_cnt_legal: assert (byte_strip_cnt != '0 && byte_strip_cnt <= MAX_N);
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: fixed packet table, hand-built stall and
// reset sequences, then random packets against a byte-stream reference model.
module tb_axi_stream_strip_header;
    import axi_stream_hdr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_header, ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic [2:0]  byte_strip_cnt;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic        rand_rdy = 1'b0;

    logic [36:0] exp_q[$];
    logic [35:0] hdr_q[$];
    logic [31:0] pkt_d[8];
    logic [3:0]  pkt_k[8];

    typedef struct {
        logic [2:0]  n;
        int          nb;
        logic [31:0] d[3];
        logic [3:0]  k[3];
        logic [35:0] hdr;
        int          nout;
        logic [36:0] out[3];
    } vec_t;

    vec_t vecs[7];

    axi_stream_strip_header dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
        .ready_header   (ready_header),
        .byte_strip_cnt (byte_strip_cnt),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every completed transfer is popped against the expected queues,
    // and a stalled beat must not change before it is taken.
    logic        stall_out = 1'b0, stall_hdr = 1'b0;
    logic [36:0] held_out;
    logic [35:0] held_hdr;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_out = 1'b0;
            stall_hdr = 1'b0;
        end else begin
            if (stall_out) check("out_stable", {valid_out, data_out, keep_out, last_out}, {1'b1, held_out});
            if (stall_hdr) check("hdr_stable", {valid_header, data_header, keep_header}, {1'b1, held_hdr});
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) check("out_unexpected", 64'(exp_q.size()), 64'd1);
                else check("payload", {data_out, keep_out, last_out}, exp_q.pop_front());
            end
            if (valid_header && ready_header) begin
                if (hdr_q.size() == 0) check("hdr_unexpected", 64'(hdr_q.size()), 64'd1);
                else check("header", {data_header, keep_header}, hdr_q.pop_front());
            end
            stall_out = valid_out && !ready_out;
            stall_hdr = valid_header && !ready_header;
            held_out  = {data_out, keep_out, last_out};
            held_hdr  = {data_header, keep_header};
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            ready_out    = ($urandom_range(0, 3) != 0);
            ready_header = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: the packet is a byte string; the header is the first beat with
    // its first N bytes enabled, the payload is everything after byte N repacked.
    task automatic model_packet(input int n, input int nb);
        logic [7:0]  bq[$];
        logic [31:0] d;
        logic [3:0]  k, hk;
        int          drop;
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < $countones(pkt_k[b]); i++)
                bq.push_back(pkt_d[b][31-8*i -: 8]);
        hk = 4'h0;
        for (int i = 0; i < n; i++) hk[3-i] = 1'b1;
        hdr_q.push_back({pkt_d[0], hk});
        drop = (n < bq.size()) ? n : bq.size();
        repeat (drop) void'(bq.pop_front());
        while (bq.size() > 0) begin
            d = '0;
            k = '0;
            for (int i = 0; i < 4; i++)
                if (bq.size() > 0) begin
                    d[31-8*i -: 8] = bq.pop_front();
                    k[3-i] = 1'b1;
                end
            exp_q.push_back({d, k, bq.size() == 0});
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] n);
        valid_in       = 1'b1;
        data_in        = d;
        keep_in        = k;
        last_in        = l;
        byte_strip_cnt = n;
    endtask

    task automatic wait_accept();
        int w = 0;
        @(negedge clk);
        while (!ready_in && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("beat_accepted", ready_in, 1'b1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_out", 64'(exp_q.size()), 64'd0);
        check("drain_hdr", 64'(hdr_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // N is driven only meaningfully on the first beat; later beats carry noise.
    task automatic send_packet(input int n, input int nb, input int max_gap);
        model_packet(n, nb);
        for (int b = 0; b < nb; b++) begin
            drive_beat(pkt_d[b], pkt_k[b], b == nb - 1,
                       (b == 0) ? 3'(n) : 3'($urandom_range(1, 4)));
            wait_accept();
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic rand_packet(output int n, output int nb);
        int l;
        n  = $urandom_range(1, 4);
        nb = $urandom_range(1, 4);
        l  = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
            pkt_d[b] = $urandom();
            pkt_k[b] = 4'hF;
        end
        pkt_k[nb-1] = 4'hF << (4 - l);
        for (int i = l; i < 4; i++) pkt_d[nb-1][31-8*i -: 8] = 8'h00;
    endtask

    task automatic set_vec(input int idx, input logic [2:0] n, input int nb,
                           input logic [31:0] d0, input logic [3:0] k0,
                           input logic [31:0] d1, input logic [3:0] k1,
                           input logic [31:0] d2, input logic [3:0] k2,
                           input logic [35:0] hdr, input int nout,
                           input logic [36:0] o0, input logic [36:0] o1);
        vecs[idx].n    = n;
        vecs[idx].nb   = nb;
        vecs[idx].d    = '{d0, d1, d2};
        vecs[idx].k    = '{k0, k1, k2};
        vecs[idx].hdr  = hdr;
        vecs[idx].nout = nout;
        vecs[idx].out  = '{o0, o1, 37'h0};
    endtask

    initial begin
        int rn, rnb;
        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b1; ready_header = 1'b1; byte_strip_cnt = 3'd1;

        set_vec(0, 3'd2, 3, 32'hAABB1122, 4'hF, 32'h33445566, 4'hF, 32'h77880000, 4'hC,
                {32'hAABB1122, 4'hC}, 2, {32'h11223344, 4'hF, 1'b0}, {32'h55667788, 4'hF, 1'b1});
        set_vec(1, 3'd1, 2, 32'hEE112233, 4'hF, 32'h44556677, 4'hE, 32'h0, 4'h0,
                {32'hEE112233, 4'h8}, 2, {32'h11223344, 4'hF, 1'b0}, {32'h55667700, 4'hC, 1'b1});
        set_vec(2, 3'd4, 1, 32'hDEADBEEF, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0,
                {32'hDEADBEEF, 4'hF}, 0, 37'h0, 37'h0);
        set_vec(3, 3'd3, 2, 32'h01020304, 4'hF, 32'h05000000, 4'h8, 32'h0, 4'h0,
                {32'h01020304, 4'hE}, 1, {32'h04050000, 4'hC, 1'b1}, 37'h0);
        set_vec(4, 3'd4, 2, 32'hCAFEF00D, 4'hF, 32'h12345678, 4'hF, 32'h0, 4'h0,
                {32'hCAFEF00D, 4'hF}, 1, {32'h12345678, 4'hF, 1'b1}, 37'h0);
        set_vec(5, 3'd3, 1, 32'hA1B2C3D4, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0,
                {32'hA1B2C3D4, 4'hE}, 1, {32'hD4000000, 4'h8, 1'b1}, 37'h0);
        set_vec(6, 3'd2, 1, 32'h99000000, 4'h8, 32'h0, 4'h0, 32'h0, 4'h0,
                {32'h99000000, 4'hC}, 0, 37'h0, 37'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {valid_out, last_out, valid_header, data_out, keep_out, data_header, keep_header}, 64'h0);
        check("rst_state", state_dbg, IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_in", ready_in, 1'b1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            hdr_q.push_back(vecs[v].hdr);
            for (int o = 0; o < vecs[v].nout; o++) exp_q.push_back(vecs[v].out[o]);
            for (int b = 0; b < vecs[v].nb; b++) begin
                drive_beat(vecs[v].d[b], vecs[v].k[b], b == vecs[v].nb - 1, vecs[v].n);
                wait_accept();
            end
            wait_drain();
        end

        // FLUSH holds off the input while its residual beat waits.
        pkt_d[0] = 32'hEE112233; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'h44556600; pkt_k[1] = 4'hE;
        model_packet(1, 2);
        drive_beat(pkt_d[0], pkt_k[0], 1'b0, 3'd1); wait_accept();
        drive_beat(pkt_d[1], pkt_k[1], 1'b1, 3'd1); wait_accept();
        ready_out = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("flush_state", state_dbg, FLUSH);
            check("flush_ready_in", ready_in, 1'b0);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        wait_drain();

        // Full-width header on a single beat produces no payload at all.
        pkt_d[0] = 32'hDEADBEEF; pkt_k[0] = 4'hF;
        model_packet(4, 1);
        drive_beat(pkt_d[0], pkt_k[0], 1'b1, 3'd4); wait_accept();
        repeat (3) begin
            @(negedge clk);
            check("n4_no_payload", valid_out, 1'b0);
            check("n4_idle", state_dbg, IDLE);
        end
        wait_drain();

        // Output backpressure mid-packet.
        pkt_d[0] = 32'h0A0B0C0D; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'h11121314; pkt_k[1] = 4'hF;
        pkt_d[2] = 32'h15160000; pkt_k[2] = 4'hC;
        model_packet(2, 3);
        drive_beat(pkt_d[0], pkt_k[0], 1'b0, 3'd2); wait_accept();
        ready_out = 1'b0;
        drive_beat(pkt_d[1], pkt_k[1], 1'b0, 3'd2); wait_accept();
        drive_beat(pkt_d[2], pkt_k[2], 1'b1, 3'd2);
        repeat (3) begin
            @(negedge clk);
            check("stall_ready_in", ready_in, 1'b0);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        wait_accept();
        wait_drain();

        // An untaken header blocks the next packet's first beat.
        ready_header = 1'b0;
        pkt_d[0] = 32'h11223344; pkt_k[0] = 4'hF;
        model_packet(2, 1);
        drive_beat(pkt_d[0], pkt_k[0], 1'b1, 3'd2); wait_accept();
        pkt_d[0] = 32'h55667788; pkt_k[0] = 4'hF;
        model_packet(1, 1);
        drive_beat(pkt_d[0], pkt_k[0], 1'b1, 3'd1);
        repeat (3) begin
            @(negedge clk);
            check("hdr_block_ready_in", ready_in, 1'b0);
        end
        @(posedge clk);
        #1;
        ready_header = 1'b1;
        wait_accept();
        wait_drain();

        // Reset in the middle of a packet, with a payload beat still pending.
        hdr_q.push_back({32'hCAFEBABE, 4'hC});
        drive_beat(32'hCAFEBABE, 4'hF, 1'b0, 3'd2); wait_accept();
        ready_out = 1'b0;
        drive_beat(32'h01234567, 4'hF, 1'b0, 3'd2); wait_accept();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_out = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {valid_out, last_out, valid_header, data_out, keep_out, data_header, keep_header}, 64'h0);
        check("midrst_state", state_dbg, IDLE);
        @(posedge clk);
        #1;
        pkt_d[0] = 32'h10203040; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'h50600000; pkt_k[1] = 4'hC;
        send_packet(3, 2, 0);
        wait_drain();

        rand_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            rand_packet(rn, rnb);
            send_packet(rn, rnb, 2);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        ready_header = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: time limit reached, exp_q=%0d hdr_q=%0d", exp_q.size(), hdr_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
